// File: rtl/stoch_pkg.sv
// Shared types for the stochastic-computing blocks.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stoch_state_t;

endpackage

// File: rtl/stoch_decode.sv
// Stochastic bitstream decoder: counts ones over a window of 2^WINDOW_LOG2
// qualified samples and presents the result (unipolar or bipolar) with a valid/ready hold.
module stoch_decode
    import stoch_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int BIPOLAR     = 0
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   a,
    input  logic                   a_valid,
    output logic [WINDOW_LOG2:0]   y,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic                   busy
);

    localparam int CW = WINDOW_LOG2;
    localparam int YW = WINDOW_LOG2 + 1;
    localparam logic [YW-1:0] N_VAL = YW'(1) << WINDOW_LOG2;

    stoch_state_t     state, state_nxt;
    logic [YW-1:0]    acc, acc_nxt, acc_inc, result;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [YW-1:0]    y_q, y_nxt;

    assign acc_inc = acc + {{CW{1'b0}}, a};

    // 2*ones - N wraps correctly in YW bits; ones == N would read as -N, so clamp it.
    always_comb begin
        result = acc_inc;
        if (BIPOLAR != 0) begin
            if (acc_inc == N_VAL)
                result = N_VAL - YW'(1);
            else
                result = (acc_inc << 1) - N_VAL;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        y_nxt     = y_q;
        if (abort) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (a_valid) begin
                        acc_nxt = acc_inc;
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == {CW{1'b1}}) begin
                            y_nxt     = result;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        if (start) begin
                            acc_nxt   = '0;
                            cnt_nxt   = '0;
                            state_nxt = ACCUM;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            y_q   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            y_q   <= y_nxt;
        end
    end

    assign y       = y_q;
    assign y_valid = (state == HOLD);
    assign busy    = (state == ACCUM);

endmodule

// File: doc/stoch_decode.md
STOCH_DECODE -- requirements
Module: stoch_decode

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 8: log2 of the number of qualified bitstream samples per conversion window (N = 2^WINDOW_LOG2).
REQ-002 SHALL have parameter BIPOLAR, default 0: 0 selects unipolar result (ones count), 1 selects bipolar result (2*ones - N, two's complement).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin a conversion window.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of any conversion in progress.
REQ-007 SHALL have port a, input, 1, stochastic bitstream sample.
REQ-008 SHALL have port a_valid, input, 1, qualifies a in the current cycle.
REQ-009 SHALL have port y, output, WINDOW_LOG2+1, conversion result (signed when BIPOLAR=1).
REQ-010 SHALL have port y_valid, output, 1, y holds a completed result.
REQ-011 SHALL have port y_ready, input, 1, consumer accepts y.
REQ-012 SHALL have port busy, output, 1, high while a window is accumulating.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, HOLD; IDLE after reset.
REQ-014 IDLE: start=1 SHALL clear the ones accumulator and sample counter and enter ACCUM next cycle; a during the start cycle is not sampled.
REQ-015 ACCUM: each cycle with a_valid=1 SHALL add a to the accumulator and increment the sample counter; a_valid=0 cycles SHALL leave both unchanged.
REQ-016 Accumulator SHALL be WINDOW_LOG2+1 bits so a count of N does not overflow; sample counter SHALL be WINDOW_LOG2 bits and wrap to 0 at the final sample.
REQ-017 On the cycle the N-th qualified sample is accepted, SHALL register the final result (including that sample) into y, enter HOLD, and assert y_valid on the next cycle (latency: 1 cycle after last sample).
REQ-018 BIPOLAR=1: y SHALL equal 2*ones - N computed in WINDOW_LOG2+1 bits two's complement; ones = N SHALL saturate to 2^WINDOW_LOG2 - 1; ones = 0 SHALL yield -N.
REQ-019 HOLD: y and y_valid SHALL remain stable until y_valid & y_ready; a is ignored.
REQ-020 Handshake complete with start=0 SHALL go IDLE; with start=1 in the same cycle SHALL clear and go ACCUM (back-to-back windows, no idle cycle).
REQ-021 start in ACCUM or HOLD without handshake SHALL be ignored.
REQ-022 abort=1 in any state SHALL force IDLE next cycle, clear y_valid, and take priority over start, a_valid, and y_ready.
REQ-023 busy SHALL be 1 exactly in ACCUM; y_valid SHALL be 1 exactly in HOLD.
REQ-024 y SHALL retain its last registered value in IDLE and ACCUM; it is meaningful only when y_valid=1.

Reset
REQ-025 nRST=0 SHALL immediately, without a clock edge, set state IDLE, accumulator 0, sample counter 0, y 0, y_valid 0, busy 0.
REQ-026 Reset assertion mid-ACCUM or mid-HOLD SHALL discard the partial or pending result; after release, nothing happens until a new start.

Structure
REQ-027 The FSM state enum typedef SHALL reside in the shared stochastic package stoch_pkg; WINDOW_LOG2-derived widths SHALL be local constants.
REQ-028 SHALL be a single module with no sub-module; the bitstream source (fibonacci_lfsr-based generator or decorrelator) is external.

Verification (WINDOW_LOG2=4, N=16)
REQ-029 Unipolar, start, then 16 valid samples with 12 ones -> y=12, y_valid high 1 cycle after the 16th sample, busy low in HOLD.
REQ-030 Unipolar, all 16 ones -> y=16; BIPOLAR=1 same stream -> y=15 (saturated); BIPOLAR=1 all zeros -> y=-16 (5'b10000).
REQ-031 Valid samples interleaved with a_valid=0 gaps and a=1 during gaps -> gaps ignored, y equals ones among qualified samples only.
REQ-032 HOLD with y_ready low 10 cycles, then y_ready & start together -> y stable throughout; next cycle ACCUM with cleared counts, second window result independent of first.
REQ-033 abort at sample 7 of ACCUM with start also high -> IDLE next cycle, y_valid never asserted; subsequent start produces a correct full window.
REQ-034 nRST pulsed low between clock edges mid-ACCUM -> outputs zero immediately; no y_valid until a new start and 16 samples.
